// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch control block: FSM state
// encoding, instruction-memory geometry and the queue entry layout.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam int IM_WORDS = 1024;
  localparam int INSTR_W  = 32;
  localparam int PC_W     = 64;
  // Word-index width into instruction memory (10 bits for 1024 words).
  localparam int IM_IDX_W = $clog2(IM_WORDS);

  // One fetched instruction together with the byte PC it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_ent_t;

  // Instructions are word aligned; any low-bit set is a misaligned fetch.
  function automatic logic pc_misaligned(input logic [PC_W-1:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/if_queue.sv
// Small circular FIFO holding fetched instructions between fetch and decode.
// DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
// A push while full is accepted only when a pop happens in the same cycle.
// Flush empties the queue in one cycle and takes priority over push/pop.
module if_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 96
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_dout,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  assign w_full  = (r_count == (PW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = i_push && (!w_full || i_pop);
  assign w_pop   = i_pop && !w_empty;

  // Pointer and occupancy bookkeeping; flush and reset both empty the queue.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; no reset needed since the head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush && !reset) r_mem[r_wr_ptr] <= i_din;
  end

  // Head entry reads as zero when empty so outputs are clean after reset/flush.
  assign o_dout  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/if_control.sv
// Instruction-fetch control: IDLE/FETCH/HALT FSM, PC register, sticky fault
// and an instruction queue (if_queue) feeding decode.
// Optional macro IF_CTRL_BOUND_CHECK_EN: when defined, a PC outside the
// 4 KiB instruction memory faults like a misaligned PC; when undefined the
// upper PC bits are ignored and im_addr aliases modulo IM_WORDS.
module if_control
  import if_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          QDEPTH   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [63:0]         im_addr,
  input  logic [INSTR_W-1:0]  im_instr,
  input  logic                br_valid,
  input  logic [63:0]         br_target,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSTR_W-1:0]  out_instr,
  output logic [63:0]         out_pc,
  output logic                fault
);

  localparam int CW = $clog2(QDEPTH) + 1;

  state_t        r_state;
  logic [63:0]   r_pc;
  logic          r_fault;

  logic          w_fault_det;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  fetch_ent_t    w_din;
  fetch_ent_t    w_dout;

  // Fault detection only matters while actively fetching.
  always_comb begin
    w_fault_det = 1'b0;
    if (r_state == FETCH) begin
      w_fault_det = pc_misaligned(r_pc);
`ifdef IF_CTRL_BOUND_CHECK_EN
      if (r_pc[63:IM_IDX_W+2] != '0) w_fault_det = 1'b1;
`endif
    end
  end

  assign w_full  = (w_count == CW'(QDEPTH));
  assign w_empty = (w_count == '0);

  // A redirect suppresses both queue ops; a full queue still takes a push
  // when the head is leaving in the same cycle.
  assign w_pop  = !w_empty && out_ready && !br_valid;
  assign w_push = (r_state == FETCH) && !br_valid && !w_fault_det &&
                  (!w_full || w_pop);

  assign w_din.instr = im_instr;
  assign w_din.pc    = r_pc;

  // FSM, PC and sticky fault; reset beats redirect, redirect beats start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
    end else if (br_valid) begin
      r_pc    <= br_target;
      r_fault <= 1'b0;
      if (r_state == HALT) r_state <= FETCH;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) r_state <= FETCH;
        end
        FETCH: begin
          if (w_fault_det) begin
            r_fault <= 1'b1;
            r_state <= HALT;
          end else if (w_push) begin
            r_pc <= r_pc + 64'd4;
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  if_queue #(
    .DEPTH (QDEPTH),
    .W     ($bits(fetch_ent_t))
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (br_valid),
    .i_din   (w_din),
    .o_dout  (w_dout),
    .o_count (w_count)
  );

  // Memory is addressed by word index from the low PC bits in every state.
  assign im_addr   = {{(64-IM_IDX_W){1'b0}}, r_pc[IM_IDX_W+1:2]};
  assign out_valid = !w_empty;
  assign out_instr = w_dout.instr;
  assign out_pc    = w_dout.pc;
  assign fault     = r_fault;

endmodule
